// File: rtl/seq_bit_serializer.sv
// seq_bit_serializer: accepts parallel words over valid/ready and shifts them out one bit per clock.
// Optional macro SER_PARITY_EN appends an even-parity bit after the last data bit of each word.
module seq_bit_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned GAP       = 0,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             ser_bit,
    output logic             ser_valid,
    output logic             busy,
    output logic [15:0]      words_sent
);

`ifdef SER_PARITY_EN
    localparam int unsigned LAST = WIDTH;
`else
    localparam int unsigned LAST = WIDTH - 1;
`endif
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);
    localparam int unsigned GAP_W = 4;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] shreg;
    logic [CNT_W-1:0] bit_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic             last_bit;
    logic             load;
`ifdef SER_PARITY_EN
    logic             par;
`endif

    // First bit to leave the word, and the word with that bit consumed.
    function automatic logic head_of(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    function automatic logic [WIDTH-1:0] shift_of(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    assign last_bit  = (state == S_SHIFT) && (bit_cnt == CNT_W'(LAST));
    assign din_ready = (state == S_IDLE) || (last_bit && (GAP == 0));
    assign load      = din_valid && din_ready;
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            shreg      <= '0;
            bit_cnt    <= '0;
            gap_cnt    <= '0;
            ser_bit    <= 1'b0;
            ser_valid  <= 1'b0;
            words_sent <= '0;
`ifdef SER_PARITY_EN
            par        <= 1'b0;
`endif
        end else begin
            if (last_bit) begin
                words_sent <= words_sent + 16'd1;
            end

            if (load) begin
                // Head bit goes straight to the output register; the rest waits in shreg.
                state     <= S_SHIFT;
                shreg     <= shift_of(din);
                ser_bit   <= head_of(din);
                ser_valid <= 1'b1;
                bit_cnt   <= '0;
`ifdef SER_PARITY_EN
                par       <= ^din;
`endif
            end else begin
                case (state)
                    S_SHIFT: begin
                        if (last_bit) begin
                            ser_bit   <= 1'b0;
                            ser_valid <= 1'b0;
                            gap_cnt   <= '0;
                            state     <= (GAP != 0) ? S_GAP : S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                            shreg   <= shift_of(shreg);
`ifdef SER_PARITY_EN
                            ser_bit <= (bit_cnt == CNT_W'(WIDTH - 1)) ? par : head_of(shreg);
`else
                            ser_bit <= head_of(shreg);
`endif
                        end
                    end
                    S_GAP: begin
                        gap_cnt <= gap_cnt + GAP_W'(1);
                        if (gap_cnt == GAP_W'(GAP - 1)) begin
                            state <= S_IDLE;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_seq_bit_serializer.sv
// Directed bench for seq_bit_serializer: unit 0 is MSB-first with no gap, unit 1 is LSB-first with GAP=3.
module tb_seq_bit_serializer;

`ifdef SER_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif

    logic        clk;
    logic        reset;
    logic [7:0]  dn [2];
    logic        dv [2];
    logic        rdy[2];
    logic        sb [2];
    logic        sv [2];
    logic        bz [2];
    logic [15:0] ws [2];

    int errors = 0;
    int checks = 0;

    seq_bit_serializer #(.WIDTH(8), .GAP(0), .MSB_FIRST(1'b1)) u_dut0 (
        .clk(clk), .reset(reset), .din(dn[0]), .din_valid(dv[0]), .din_ready(rdy[0]),
        .ser_bit(sb[0]), .ser_valid(sv[0]), .busy(bz[0]), .words_sent(ws[0])
    );

    seq_bit_serializer #(.WIDTH(8), .GAP(3), .MSB_FIRST(1'b0)) u_dut1 (
        .clk(clk), .reset(reset), .din(dn[1]), .din_valid(dv[1]), .din_ready(rdy[1]),
        .ser_bit(sb[1]), .ser_valid(sv[1]), .busy(bz[1]), .words_sent(ws[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle(input int u, input string tag, input logic [15:0] exp_ws);
        check($sformatf("%s u%0d ser_valid", tag, u), 32'(sv[u]), 32'd0);
        check($sformatf("%s u%0d ser_bit", tag, u), 32'(sb[u]), 32'd0);
        check($sformatf("%s u%0d busy", tag, u), 32'(bz[u]), 32'd0);
        check($sformatf("%s u%0d din_ready", tag, u), 32'(rdy[u]), 32'd1);
        check($sformatf("%s u%0d words_sent", tag, u), 32'(ws[u]), 32'(exp_ws));
    endtask

    // Checks every serial cycle of one word, starting in its first bit cycle.
    task automatic stream_word(input int u, input logic [7:0] w, input bit lsb, input bit rdy_last);
        logic e;
        for (int i = 0; i < NB; i++) begin
            if (i < 8) e = lsb ? w[i] : w[7 - i];
            else       e = ^w;
            check($sformatf("u%0d w%02h bit%0d valid", u, w, i), 32'(sv[u]), 32'd1);
            check($sformatf("u%0d w%02h bit%0d data", u, w, i), 32'(sb[u]), 32'(e));
            check($sformatf("u%0d w%02h bit%0d ready", u, w, i), 32'(rdy[u]),
                  32'(rdy_last && (i == NB - 1)));
            check($sformatf("u%0d w%02h bit%0d busy", u, w, i), 32'(bz[u]), 32'd1);
            tick();
        end
    endtask

    initial begin
        reset = 1'b0;
        dn[0] = 8'h00; dv[0] = 1'b0;
        dn[1] = 8'h00; dv[1] = 1'b0;

        repeat (3) @(posedge clk);
        #1;
        check("in_reset u0 ser_valid", 32'(sv[0]), 32'd0);
        reset = 1'b1;
        #1;
        check_idle(0, "reset", 16'd0);
        check_idle(1, "reset", 16'd0);
        tick();

        // Single MSB-first word 0x93.
        dn[0] = 8'h93; dv[0] = 1'b1;
        tick();
        dv[0] = 1'b0;
        stream_word(0, 8'h93, 1'b0, 1'b1);
        check_idle(0, "single", 16'd1);

        // Back-to-back 0xA5 then 0x3C with valid held high.
        dn[0] = 8'hA5; dv[0] = 1'b1;
        tick();
        dn[0] = 8'h3C;
        stream_word(0, 8'hA5, 1'b0, 1'b1);
        dv[0] = 1'b0;
        check("b2b words_sent after first", 32'(ws[0]), 32'd2);
        stream_word(0, 8'h3C, 1'b0, 1'b1);
        check_idle(0, "b2b", 16'd3);

        // LSB-first with a 3-cycle gap; next word is held off until the gap ends.
        dn[1] = 8'h01; dv[1] = 1'b1;
        tick();
        dn[1] = 8'h80;
        stream_word(1, 8'h01, 1'b1, 1'b0);
        for (int g = 0; g < 3; g++) begin
            check($sformatf("gap%0d ser_valid", g), 32'(sv[1]), 32'd0);
            check($sformatf("gap%0d ser_bit", g), 32'(sb[1]), 32'd0);
            check($sformatf("gap%0d din_ready", g), 32'(rdy[1]), 32'd0);
            check($sformatf("gap%0d busy", g), 32'(bz[1]), 32'd1);
            tick();
        end
        check_idle(1, "post_gap", 16'd1);
        tick();
        dv[1] = 1'b0;
        stream_word(1, 8'h80, 1'b1, 1'b0);
        repeat (3) tick();
        check_idle(1, "second_gap", 16'd2);

        // Asynchronous reset during the fourth bit of 0xFF.
        dn[0] = 8'hFF; dv[0] = 1'b1;
        tick();
        dv[0] = 1'b0;
        repeat (3) tick();
        check("midword ser_valid before reset", 32'(sv[0]), 32'd1);
        check("midword ser_bit before reset", 32'(sb[0]), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("async ser_valid", 32'(sv[0]), 32'd0);
        check("async ser_bit", 32'(sb[0]), 32'd0);
        check("async words_sent", 32'(ws[0]), 32'd0);
        check("async busy", 32'(bz[0]), 32'd0);
        check("async u1 words_sent", 32'(ws[1]), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        tick();
        for (int k = 0; k < NB + 2; k++) begin
            check($sformatf("post_reset%0d ser_valid", k), 32'(sv[0]), 32'd0);
            check($sformatf("post_reset%0d ser_bit", k), 32'(sb[0]), 32'd0);
            tick();
        end
        check_idle(0, "post_reset", 16'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_bit_serializer.md
Name: seq_bit_serializer

Overview:
- Upstream stage of the serial sequence detector.
- Accepts parallel words over a valid/ready handshake and shifts them out one bit per clock.
- Outputs are a registered bit stream (ser_bit) plus a qualifier (ser_valid), which drive the detector's serial input.
- Supports back-to-back words with no bubble, an optional inter-word idle gap, and a sent-word counter for debug.

Parameters:
- WIDTH, 8: bits per word. Legal range 2..32.
- GAP, 0: idle cycles inserted after each word. Legal range 0..15.
- MSB_FIRST, 1: 1 shifts din[WIDTH-1] first; 0 shifts din[0] first.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous reset, active-low. 0 clears all state immediately.
- din  in  WIDTH  parallel word to transmit.
- din_valid  in  1  din holds a word.
- din_ready  out  1  block accepts din this cycle.
- ser_bit  out  1  serial data bit; feeds the detector's serial input.
- ser_valid  out  1  ser_bit is a live data bit this cycle.
- busy  out  1  state != IDLE.
- words_sent  out  16  count of fully transmitted words; wraps.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; shift register, bit_cnt and gap_cnt = 0.
  - ser_bit=0, ser_valid=0, words_sent=0.
  - Any word in flight is discarded with no partial completion.
  - busy=0; din_ready=1 once reset deasserts.
- Handshake:
  - Transfer occurs on a rising edge where din_valid=1 and din_ready=1.
  - din is sampled only at that edge.
  - din_valid=1 with din_ready=0 is legal. The word is held off and no bits are lost.
- din_ready is combinational from state only, never from din_valid. It is 1 when:
  - state=IDLE, or
  - state=SHIFT and bit_cnt=WIDTH-1 and GAP=0.
- FSM states: IDLE, SHIFT, GAP.
  - IDLE: ser_valid=0, ser_bit=0. On transfer, load the word, set bit_cnt=0, go to SHIFT.
  - SHIFT:
    - ser_valid=1; ser_bit is the current head bit (registered output).
    - Each edge advances one bit and increments bit_cnt.
    - At bit_cnt=WIDTH-1 the edge completes the word and increments words_sent. The next state is then:
      - GAP>0: go to GAP with gap_cnt=0.
      - GAP=0 with a transfer on the same edge: stay in SHIFT, reload, bit_cnt=0. Zero-bubble output.
      - GAP=0 with no transfer: go to IDLE.
  - GAP: ser_valid=0, ser_bit=0. gap_cnt increments each edge. At gap_cnt=GAP-1, go to IDLE.
- Latency:
  - First data bit appears (ser_valid=1) in the cycle right after the accepting edge.
  - A word occupies exactly WIDTH consecutive ser_valid cycles.
- Bit order is fixed at load time per MSB_FIRST.
- words_sent increments only on word completion. It wraps 16'hFFFF -> 0.
- While ser_valid=0, ser_bit must be 0 so the detector sees a clean idle level.

Optional Feature:
- Macro: SER_PARITY_EN.
- Defined:
  - After the last data bit, one extra SHIFT cycle is emitted with ser_valid=1 and ser_bit = even parity (XOR of the WIDTH data bits).
  - A word occupies WIDTH+1 valid cycles.
  - The din_ready back-to-back condition moves to the parity cycle.
  - words_sent increments on the parity cycle's edge.
- Undefined: no parity cycle and no parity logic; behaviour exactly as above.

Test Plan:
- Reset, idle: reset=0 for 3 cycles, then 1 -> ser_valid=0, ser_bit=0, busy=0, din_ready=1, words_sent=0.
- Single word: WIDTH=8, MSB_FIRST=1, din=8'h93 accepted at edge N -> ser_bit sequence 1,0,0,1,0,0,1,1 on cycles N+1..N+8 with ser_valid=1; IDLE at N+9; words_sent=1.
- Back-to-back: GAP=0, din_valid held high with words 8'hA5 then 8'h3C -> 16 contiguous ser_valid cycles, no bubble; din_ready high only in the 8th bit cycle; words_sent=2.
- Gap and LSB-first:
  - GAP=3, MSB_FIRST=0, din=8'h01 -> ser_bit 1,0,0,0,0,0,0,0.
  - Then 3 cycles of ser_valid=0 with din_ready=0.
  - Next word accepted no earlier than the cycle after the gap.
- Reset mid-word: reset=0 asynchronously during bit 4 of 8'hFF -> ser_valid and ser_bit drop to 0 without waiting for a clock; words_sent=0; no remaining bits are emitted after release.
- Parity (SER_PARITY_EN defined): din=8'h07 -> 8 data bits, then a ninth valid bit =1; words_sent increments after the ninth bit. Wrap check: preload by sending 65536 words -> words_sent returns to 0.
